// File: rtl/scroll_engine_pkg.sv
// Shared types and constants for the console scroll engine.
//   Scrolling_t    : scroll request from cursor control (dir, step, top, bottom)
//   ScrollState_t  : scroll engine FSM states
//   line_is_copy() : decides whether a destination line is copied or blanked
package scroll_engine_pkg;

    localparam int CONSOLE_LINES   = 24;
    localparam int CONSOLE_COLUMNS = 80;
    localparam int TEXT_ADDR_W     = 12;
    localparam int TEXT_CELL_W     = 16;

    localparam logic [TEXT_CELL_W-1:0] BLANK_CELL_DEFAULT = 16'h0720;

    // dir: 0 = up, 1 = down
    typedef struct packed {
        logic       dir;
        logic [7:0] step;
        logic [7:0] top;
        logic [7:0] bottom;
    } Scrolling_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        COPY,
        FILL,
        DONE
    } ScrollState_t;

    // Destination line l takes its content from l+step (up) or l-step (down)
    // when that source still lies inside the region; otherwise it is blanked.
    // 9-bit sums keep line+step from wrapping.
    function automatic logic line_is_copy(
        input logic       dir,
        input logic [7:0] line,
        input logic [7:0] top,
        input logic [7:0] bottom,
        input logic [8:0] estep
    );
        if (!dir) begin
            return ({1'b0, line} + estep) <= {1'b0, bottom};
        end
        return {1'b0, line} >= ({1'b0, top} + estep);
    endfunction

endpackage

// File: rtl/scroll_engine_slot.sv
// One-entry pending buffer for scroll requests arriving while the engine is busy.
//   clk_i, rst_n_i : clock, synchronous active-low reset
//   push_i, data_i : store a request
//   pop_i          : release the stored request (may coincide with push_i)
//   full_o, data_o : slot status and stored request
//   dropped_o      : one-cycle pulse when a push hits a full slot that is not popping
module scroll_req_slot
    import scroll_engine_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       push_i,
    input  Scrolling_t data_i,
    input  logic       pop_i,
    output logic       full_o,
    output Scrolling_t data_o,
    output logic       dropped_o
);

    logic       full_q, full_d;
    Scrolling_t data_q, data_d;
    logic       dropped_q, dropped_d;

    always_comb begin
        full_d    = full_q;
        data_d    = data_q;
        dropped_d = 1'b0;
        if (pop_i) begin
            full_d = 1'b0;
        end
        if (push_i) begin
            if (full_q && !pop_i) begin
                dropped_d = 1'b1;
            end else begin
                full_d = 1'b1;
                data_d = data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            full_q    <= 1'b0;
            data_q    <= '0;
            dropped_q <= 1'b0;
        end else begin
            full_q    <= full_d;
            data_q    <= data_d;
            dropped_q <= dropped_d;
        end
    end

    assign full_o    = full_q;
    assign data_o    = data_q;
    assign dropped_o = dropped_q;

endmodule

// File: rtl/scroll_engine.sv
// Scroll engine: shifts a line region of the text RAM up or down by `step`
// lines and blanks the vacated lines, using a dedicated single RAM port.
//   clk_i, rst_n_i            : clock, synchronous active-low reset
//   req_valid_i, req_i        : single-cycle scroll request
//   ram_addr_o/we_o/wdata_o   : text RAM port (line*COLUMNS+col)
//   ram_rdata_i               : read data, one cycle after a read address
//   busy_o                    : request executing or pending
//   done_o                    : one-cycle pulse at request completion
//   dropped_o                 : one-cycle pulse when a request is lost
//
// state | meaning
// IDLE  | waiting for a request
// SETUP | validate request, clip step, pick first destination line
// COPY  | even phase reads source cell, odd phase writes destination cell
// FILL  | write BLANK_CELL across the destination line
// DONE  | done pulse; launch pending request or return to IDLE
module scroll_engine
    import scroll_engine_pkg::*;
#(
    parameter int                LINES      = CONSOLE_LINES,
    parameter int                COLUMNS    = CONSOLE_COLUMNS,
    parameter int                CELL_W     = TEXT_CELL_W,
    parameter int                ADDR_W     = TEXT_ADDR_W,
    parameter logic [CELL_W-1:0] BLANK_CELL = BLANK_CELL_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_valid_i,
    input  Scrolling_t        req_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [CELL_W-1:0] ram_wdata_o,
    input  logic [CELL_W-1:0] ram_rdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              dropped_o
);

    localparam logic [8:0]        LINES_9  = 9'(LINES);
    localparam logic [7:0]        COL_LAST = 8'(COLUMNS - 1);
    localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLUMNS);

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [7:0] line, input logic [7:0] col);
        return ADDR_W'(line) * COLS_A + ADDR_W'(col);
    endfunction

    ScrollState_t state_q, state_d;
    logic         dir_q, dir_d;
    logic [7:0]   top_q, top_d;
    logic [7:0]   bot_q, bot_d;
    logic [7:0]   step_q, step_d;
    logic [8:0]   estep_q, estep_d;
    logic [7:0]   line_q, line_d;
    logic [7:0]   col_q, col_d;
    logic         ph_q, ph_d;

    logic         slot_push, slot_pop, slot_full;
    Scrolling_t   slot_data, launch;
    logic         do_load, line_end;

    logic [8:0]   height, step_clip;
    logic         req_ok, last_col, last_line;
    logic [7:0]   src_line, next_line, first_line;

    assign height     = {1'b0, bot_q} - {1'b0, top_q} + 9'd1;
    assign step_clip  = ({1'b0, step_q} > height) ? height : {1'b0, step_q};
    assign req_ok     = (top_q <= bot_q) && ({1'b0, bot_q} < LINES_9) && (step_q != 8'd0);
    assign first_line = dir_q ? bot_q : top_q;
    // A copied line always has its source inside the region, so 8 bits suffice.
    assign src_line   = dir_q ? (line_q - estep_q[7:0]) : (line_q + estep_q[7:0]);
    assign next_line  = dir_q ? (line_q - 8'd1) : (line_q + 8'd1);
    assign last_col   = (col_q == COL_LAST);
    assign last_line  = dir_q ? (line_q == top_q) : (line_q == bot_q);

    // A request landing in DONE with an empty slot is launched directly instead.
    assign slot_push = req_valid_i && (state_q != IDLE) && !((state_q == DONE) && !slot_full);

    scroll_req_slot u_slot (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .push_i    (slot_push),
        .data_i    (req_i),
        .pop_i     (slot_pop),
        .full_o    (slot_full),
        .data_o    (slot_data),
        .dropped_o (dropped_o)
    );

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        top_d       = top_q;
        bot_d       = bot_q;
        step_d      = step_q;
        estep_d     = estep_q;
        line_d      = line_q;
        col_d       = col_q;
        ph_d        = ph_q;
        launch      = req_i;
        do_load     = 1'b0;
        slot_pop    = 1'b0;
        line_end    = 1'b0;
        ram_addr_o  = '0;
        ram_we_o    = 1'b0;
        ram_wdata_o = '0;
        done_o      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    do_load = 1'b1;
                end
            end
            SETUP: begin
                if (!req_ok) begin
                    state_d = DONE;
                end else begin
                    estep_d = step_clip;
                    line_d  = first_line;
                    state_d = line_is_copy(dir_q, first_line, top_q, bot_q, step_clip) ? COPY : FILL;
                end
            end
            COPY: begin
                if (!ph_q) begin
                    ram_addr_o = cell_addr(src_line, col_q);
                    ph_d       = 1'b1;
                end else begin
                    ram_addr_o  = cell_addr(line_q, col_q);
                    ram_we_o    = 1'b1;
                    ram_wdata_o = ram_rdata_i;
                    ph_d        = 1'b0;
                    line_end    = last_col;
                    col_d       = col_q + 8'd1;
                end
            end
            FILL: begin
                ram_addr_o  = cell_addr(line_q, col_q);
                ram_we_o    = 1'b1;
                ram_wdata_o = BLANK_CELL;
                line_end    = last_col;
                col_d       = col_q + 8'd1;
            end
            DONE: begin
                done_o = 1'b1;
                if (slot_full) begin
                    do_load  = 1'b1;
                    launch   = slot_data;
                    slot_pop = 1'b1;
                end else if (req_valid_i) begin
                    do_load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (line_end) begin
            col_d = '0;
            if (last_line) begin
                state_d = DONE;
            end else begin
                line_d  = next_line;
                state_d = line_is_copy(dir_q, next_line, top_q, bot_q, estep_q) ? COPY : FILL;
            end
        end

        if (do_load) begin
            state_d = SETUP;
            dir_d   = launch.dir;
            step_d  = launch.step;
            top_d   = launch.top;
            bot_d   = launch.bottom;
            col_d   = '0;
            ph_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            top_q   <= '0;
            bot_q   <= '0;
            step_q  <= '0;
            estep_q <= '0;
            line_q  <= '0;
            col_q   <= '0;
            ph_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            top_q   <= top_d;
            bot_q   <= bot_d;
            step_q  <= step_d;
            estep_q <= estep_d;
            line_q  <= line_d;
            col_q   <= col_d;
            ph_q    <= ph_d;
        end
    end

    assign busy_o = (state_q != IDLE) || slot_full;

endmodule
